// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants for the parametrised UART receiver.
//   - parity_mode encodings (PAR_NONE / PAR_EVEN / PAR_ODD; 2'b11 behaves as none)
//   - receiver FSM state type
//   - default oversample ratio and the majority-vote sample indices
package uart_rx_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Three samples straddling the bit centre.
  function automatic int unsigned vote_lo(input int unsigned os);
    return os / 2 - 1;
  endfunction

  function automatic int unsigned vote_mid(input int unsigned os);
    return os / 2;
  endfunction

  function automatic int unsigned vote_hi(input int unsigned os);
    return os / 2 + 1;
  endfunction

  localparam int unsigned VOTE_LO_DEF  = OVERSAMPLE_DEF / 2 - 1;
  localparam int unsigned VOTE_MID_DEF = OVERSAMPLE_DEF / 2;
  localparam int unsigned VOTE_HI_DEF  = OVERSAMPLE_DEF / 2 + 1;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: oversample tick generator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the tick period and sample index (start-bit alignment)
//   div      : tick period is div+1 clk cycles (loaded on clr and on every tick)
//   tick     : one-cycle pulse per tick period
//   idx      : sample index within the current bit, 0..OVERSAMPLE-1; the value
//              seen together with tick is the index of that sample
module uart_rx_tick_gen #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned IDX_W      = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = div;
      idx_d = '0;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = div;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with 2-of-3 majority voting,
// runtime baud divisor, 5..9 data bits, optional parity, 1 or 2 stop bits and
// a valid/ready holding register.
//   clk, rst     : clock, synchronous active-high reset
//   baud_div     : oversample tick period = baud_div+1 clk (latched at start)
//   parity_mode  : 00 none, 01 even, 10 odd, 11 none (latched at start)
//   stop2        : 0 one stop bit, 1 two stop bits (latched at start)
//   rs232_rx     : asynchronous serial input, idle high
//   rx_data / parity_err / frame_err / rx_valid / rx_ready : held word + handshake
//   overrun      : one-cycle pulse when a completed frame is dropped
//   rx_busy      : receiver is inside a frame
//   rx_break     : one-cycle break pulse (macro UART_RX_BREAK_DET_EN), else 0
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy,
  output logic                 rx_break
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_VLO  = IDX_W'(vote_lo(OVERSAMPLE));
  localparam logic [IDX_W-1:0] IDX_VMID = IDX_W'(vote_mid(OVERSAMPLE));
  localparam logic [IDX_W-1:0] IDX_VHI  = IDX_W'(vote_hi(OVERSAMPLE));
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_BITS - 1);

  rx_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [1:0]             pmode_q, pmode_d;
  logic                   stop2_q, stop2_d;
  logic [1:0]             ones_q, ones_d;
  logic                   vbit_q, vbit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                   any1_q, any1_d;
  logic                   rx_break_q, rx_break_d;
`endif

  logic             line;
  logic             start_det;
  logic             brk_clr;
  logic             frame_done;
  logic             tick;
  logic [IDX_W-1:0] idx;
  logic             vote_done;
  logic             bit_end;
  logic             vbit;
  logic             par_en;

  assign line      = sync_q[SYNC_STAGES-1];
  assign start_det = (state_q == ST_IDLE) && prev_q && !line;
  assign vote_done = tick && (idx == IDX_VHI);
  assign bit_end   = tick && (idx == IDX_LAST);
  // ones_q holds the count of 1s from the first two samples.
  assign vbit      = ones_q[1] | (ones_q[0] & line);
  assign par_en    = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);

  // The live baud_div is used on the start-detect cycle so the first bit is
  // already timed with the value being latched.
  uart_rx_tick_gen #(
    .OVERSAMPLE (OVERSAMPLE),
    .DIV_W      (DIV_W),
    .IDX_W      (IDX_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det | brk_clr),
    .div  (start_det ? baud_div : div_q),
    .tick (tick),
    .idx  (idx)
  );

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], rs232_rx};
    prev_d       = line;
    state_d      = state_q;
    div_d        = div_q;
    pmode_d      = pmode_q;
    stop2_d      = stop2_q;
    ones_d       = ones_q;
    vbit_d       = vbit_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    brk_clr      = 1'b0;
    frame_done   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    any1_d       = any1_q;
    rx_break_d   = 1'b0;
`endif

    if (tick && (idx == IDX_VLO)) begin
      ones_d = {1'b0, line};
    end else if (tick && (idx == IDX_VMID)) begin
      ones_d = ones_q + {1'b0, line};
    end

    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d = ST_START;
          div_d   = baud_div;
          pmode_d = parity_mode;
          stop2_d = stop2;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          any1_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (vote_done) vbit_d = vbit;
        if (bit_end) begin
          if (vbit_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (vote_done) begin
          shift_d = {vbit, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
          any1_d  = any1_q | vbit;
`endif
        end
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = par_en ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (vote_done) begin
          perr_d = (^shift_q ^ vbit) != (pmode_q == PAR_ODD);
`ifdef UART_RX_BREAK_DET_EN
          any1_d = any1_q | vbit;
`endif
        end
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        // Completion happens at the vote of the last stop bit so a slightly
        // fast transmitter's next start edge is never missed.
        if (vote_done) begin
          ferr_d = ferr_q | ~vbit;
`ifdef UART_RX_BREAK_DET_EN
          if (!stop_cnt_q && !vbit && !any1_q) begin
            state_d    = ST_BREAK;
            rx_break_d = 1'b1;
            brk_clr    = 1'b1;
          end else
`endif
          if (stop_cnt_q == stop2_q) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BREAK: begin
        // Hold the bit timer in reset while the line is low; a full bit of
        // idle-high after that re-arms start detection.
        if (!line) begin
          brk_clr = 1'b1;
        end else if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_d;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '1;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      pmode_q      <= '0;
      stop2_q      <= 1'b0;
      ones_q       <= '0;
      vbit_q       <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      any1_q       <= 1'b0;
      rx_break_q   <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      div_q        <= div_d;
      pmode_q      <= pmode_d;
      stop2_q      <= stop2_d;
      ones_q       <= ones_d;
      vbit_q       <= vbit_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
      any1_q       <= any1_d;
      rx_break_q   <= rx_break_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q != ST_IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign rx_break   = rx_break_q;
`else
  assign rx_break   = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver, successor to the fixed 8N1 byte receiver used by the scope link. Adds runtime baud divisor, configurable data width, parity and stop bits, and majority-vote oversampling. Adds a valid/ready output holding register with error and overrun reporting. Feeds the command parser / capture-control path.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, ticks per bit; even, at least 8.
DIV_W, 16, width of baud_div.
SYNC_STAGES, 2, input synchroniser depth; at least 2.

Ports:
clk  in  1  system clock; the block's only clock.
rst  in  1  reset; synchronous, active-high.
baud_div  in  DIV_W  oversample tick period is baud_div+1 clk cycles.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
stop2  in  1  0 = one stop bit, 1 = two stop bits.
rs232_rx  in  1  asynchronous serial line, idle high.
rx_data  out  DATA_BITS  received word, LSB = first bit on the line.
rx_valid  out  1  rx_data, parity_err and frame_err are valid.
rx_ready  in  1  consumer accepts the word.
parity_err  out  1  parity mismatch on the held word.
frame_err  out  1  a stop bit sampled 0 on the held word.
overrun  out  1  one-cycle pulse: a frame was dropped because the holding register was full.
rx_busy  out  1  high whenever the FSM is not in IDLE.
rx_break  out  1  break pulse; see Optional Feature.

Behaviour:
- Reset values: all outputs 0. Synchroniser flops reset to 1. FSM goes to IDLE; tick and sample counters go to 0.
- Input path: rs232_rx passes through SYNC_STAGES flops. Start is detected in IDLE on synced previous=1, current=0.
- On start detect, the tick generator clears and config is latched: baud_div, parity_mode and stop2 are captured here. Changes mid-frame have no effect until the next frame.
- baud_div=0 gives a tick every clk.
- Timing: the tick pulses once per baud_div+1 cycles. The sample counter runs 0..OVERSAMPLE-1 per bit.
- Voting: the line is sampled at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- START: at end of bit, a majority of 1 is a false start. Return to IDLE with no flags and no output. Otherwise go to DATA.
- DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if parity is enabled, else to STOP.
- PARITY: even means XOR of data and parity bit must be 0; odd means it must be 1. A mismatch sets internal perr.
- STOP: 1 or 2 bits. Any stop bit voting 0 sets internal ferr.
- Frame completion happens at the vote of the last stop bit, not at the end of the bit. This allows back-to-back frames under a ±2% clock mismatch. The FSM returns to IDLE on the next cycle.
- Output on completion, the following cycle:
  - If the holding register is empty, or being read that same cycle (rx_valid && rx_ready): load rx_data, parity_err and frame_err from the frame; rx_valid=1.
  - Otherwise: keep the old word, drop the new one, pulse overrun for 1 cycle.
- Handshake: transfer happens on any cycle with rx_valid && rx_ready. rx_valid clears the next cycle unless a new word loads in that same cycle, in which case it stays 1 with no gap.
- Errored frames are still delivered; consumers check the flags.
- Reset mid-frame: the partial frame is discarded and the held word is cleared. The next falling edge after release is received normally.

Optional Feature:
Macro UART_RX_BREAK_DET_EN.
- With the macro: a frame where all data bits, the parity bit if enabled and the first stop bit are all 0 is a break.
  - rx_break pulses 1 cycle; nothing is loaded and overrun is unaffected.
  - The FSM waits in an extra BREAK state until the synced line is 1 for a full bit time, then returns to IDLE.
- Without the macro: rx_break is tied 0. A break is delivered as data 0 with frame_err=1. Detection re-arms on the next falling edge.

Decomposition:
- Package uart_rx_pkg holds: the parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD); the FSM state enum; default OVERSAMPLE; and the vote-index constants derived from OVERSAMPLE.
- One sub-module, uart_rx_tick_gen: the baud_div down-counter producing the tick and the sample index, with a synchronous clear on start detect.

Test Plan:
All scenarios use baud_div=3 (tick every 4 clk, 64 clk per bit) and rx_ready=1 unless stated.
- 8N1, send 0xA5 -> rx_data=0xA5, rx_valid for 1 cycle, parity_err=0, frame_err=0; rx_valid rises within 40 clk of the stop-bit midpoint.
- Even parity, send 0x07 with parity bit 0 (wrong) -> rx_data=0x07, parity_err=1. Resend with parity 1 -> parity_err=0. Odd parity with the same bit 0 -> parity_err=0.
- 20-clk low glitch on an idle line -> no rx_valid, no flags, rx_busy returns to 0.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses exactly 1 cycle. Raise rx_ready -> 0x11 transfers, rx_valid drops.
- Send 0x3C with stop bit forced 0 -> rx_data=0x3C, frame_err=1. Assert rst at data bit 3 of the next frame -> all outputs 0. The following frame 0x3C is received clean.
- DATA_BITS=7, stop2=1, back-to-back 0x41, 0x42 with the transmitter 2% fast -> both words delivered in order, no errors. With UART_RX_BREAK_DET_EN, a line held low for 12 bits -> rx_break pulse, no rx_valid.
